// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multicycle RV32I controller (slave) and its datapath/memory (master).
// The controller samples the IR fields and status, and drives every control strobe.
interface multicycle_control_unit_if;
    logic [6:0] opcode;
    logic [2:0] funct_3;
    logic [6:0] funct_7;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic [2:0] imm_src;
    logic       instr_retired;
    logic       illegal_instr;
    logic       bus_error;

    modport slave (
        input  opcode, funct_3, funct_7, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_ctrl, imm_src,
               instr_retired, illegal_instr, bus_error
    );

    modport master (
        output opcode, funct_3, funct_7, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_ctrl, imm_src,
               instr_retired, illegal_instr, bus_error
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// RV32I multicycle controller: sequences fetch/decode/execute/memory/writeback over a shared
// wait-stated memory, with a memory-wait timeout and sticky illegal/bus fault flags.
module multicycle_control_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit ENABLE_EXT     = 1'b1
) (
    input logic                        clk,
    input logic                        rstn,
    multicycle_control_unit_if.slave   bus
);
    localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MEM_ADR = 4'd2, S_MEM_READ = 4'd3,
                           S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_EXEC_R = 4'd6, S_EXEC_I = 4'd7,
                           S_ALU_WB = 4'd8, S_BRANCH = 4'd9,  S_JAL = 4'd10,    S_LUI = 4'd11,
                           S_FAULT = 4'd12;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_LUI = 7'b0110111;
    localparam logic [6:0] F7_ZERO = 7'b0000000, F7_ALT = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR = 4'b0011,
                           ALU_XOR = 4'b0100, ALU_SLT = 4'b0101, ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111,
                           ALU_SRL = 4'b1000, ALU_SRA = 4'b1001;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_error_q, bus_error_d;

    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_r, waiting, timeout_hit;
    logic [3:0] alu_op, br_op;
    logic       alu_legal, br_legal, br_neg;

    assign f3          = bus.funct_3;
    assign f7          = bus.funct_7;
    assign is_r        = (bus.opcode == OP_R);
    assign waiting     = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        alu_op    = ALU_ADD;
        alu_legal = 1'b1;
        case (f3)
            3'b000:  alu_op = (is_r && f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
        // I-type only constrains funct7 on the shift encodings, whose upper bits alias it.
        if (is_r)
            alu_legal = (f7 == F7_ZERO) || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
        else if (f3 == 3'b001)
            alu_legal = (f7 == F7_ZERO);
        else if (f3 == 3'b101)
            alu_legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
        if (!ENABLE_EXT && (f3 == 3'b001 || f3 == 3'b011 || f3 == 3'b100 || f3 == 3'b101))
            alu_legal = 1'b0;
    end

    always_comb begin
        br_op    = ALU_SUB;
        br_neg   = 1'b0;
        br_legal = 1'b1;
        case (f3)
            3'b000:  begin br_op = ALU_SUB;  br_neg = 1'b0; end
            3'b001:  begin br_op = ALU_SUB;  br_neg = 1'b1; end
            3'b100:  begin br_op = ALU_SLT;  br_neg = 1'b1; end
            3'b101:  begin br_op = ALU_SLT;  br_neg = 1'b0; end
            3'b110:  begin br_op = ALU_SLTU; br_neg = 1'b1; br_legal = ENABLE_EXT; end
            3'b111:  begin br_op = ALU_SLTU; br_neg = 1'b0; br_legal = ENABLE_EXT; end
            default: br_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        illegal_d       = illegal_q;
        bus_error_d     = bus_error_q;
        bus.mem_req     = 1'b0;
        bus.mem_write   = 1'b0;
        bus.adr_src     = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.reg_write   = 1'b0;
        bus.result_src  = 2'b00;
        bus.alu_src_a   = 2'b00;
        bus.alu_src_b   = 2'b00;
        bus.alu_ctrl    = ALU_ADD;
        bus.imm_src     = 3'b000;
        if (rstn) begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_req    = 1'b1;
                    bus.alu_src_b  = 2'b10;
                    bus.result_src = 2'b10;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        state_d      = S_DECODE;
                    end else if (timeout_hit) begin
                        state_d     = S_FAULT;
                        bus_error_d = 1'b1;
                    end
                end
                S_DECODE: begin
                    bus.alu_src_a = 2'b01;
                    bus.alu_src_b = 2'b01;
                    case (bus.opcode)
                        OP_LOAD:   state_d = S_MEM_ADR;
                        OP_STORE:  begin bus.imm_src = 3'b001; state_d = S_MEM_ADR; end
                        OP_R:      state_d = alu_legal ? S_EXEC_R : S_FAULT;
                        OP_I:      state_d = alu_legal ? S_EXEC_I : S_FAULT;
                        OP_BRANCH: begin bus.imm_src = 3'b010; state_d = br_legal ? S_BRANCH : S_FAULT; end
                        OP_JAL:    begin bus.imm_src = 3'b011; state_d = S_JAL; end
                        OP_LUI:    begin bus.imm_src = 3'b100; state_d = S_LUI; end
                        default:   state_d = S_FAULT;
                    endcase
                    if (state_d == S_FAULT)
                        illegal_d = 1'b1;
                end
                S_MEM_ADR: begin
                    bus.alu_src_a = 2'b10;
                    bus.alu_src_b = 2'b01;
                    if (f3 != 3'b010) begin
                        state_d   = S_FAULT;
                        illegal_d = 1'b1;
                    end else begin
                        state_d = (bus.opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
                    end
                end
                S_MEM_READ, S_MEM_WRITE: begin
                    bus.mem_req   = 1'b1;
                    bus.adr_src   = 1'b1;
                    bus.mem_write = (state_q == S_MEM_WRITE);
                    if (bus.mem_ready) begin
                        state_d = (state_q == S_MEM_WRITE) ? S_FETCH : S_MEM_WB;
                    end else if (timeout_hit) begin
                        state_d     = S_FAULT;
                        bus_error_d = 1'b1;
                    end
                end
                S_MEM_WB: begin
                    bus.result_src = 2'b01;
                    bus.reg_write  = 1'b1;
                    state_d        = S_FETCH;
                end
                S_EXEC_R, S_EXEC_I: begin
                    bus.alu_src_a = 2'b10;
                    bus.alu_src_b = (state_q == S_EXEC_I) ? 2'b01 : 2'b00;
                    bus.alu_ctrl  = alu_op;
                    state_d       = S_ALU_WB;
                end
                S_ALU_WB: begin
                    bus.reg_write = 1'b1;
                    state_d       = S_FETCH;
                end
                S_BRANCH: begin
                    bus.alu_src_a = 2'b10;
                    bus.alu_ctrl  = br_op;
                    bus.pc_write  = br_neg ? ~bus.zero : bus.zero;
                    state_d       = S_FETCH;
                end
                S_JAL: begin
                    bus.alu_src_a = 2'b01;
                    bus.alu_src_b = 2'b10;
                    bus.pc_write  = 1'b1;
                    state_d       = S_ALU_WB;
                end
                S_LUI: begin
                    bus.alu_src_a = 2'b11;
                    bus.alu_src_b = 2'b01;
                    bus.imm_src   = 3'b100;
                    state_d       = S_ALU_WB;
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_FETCH;
            endcase
        end
        bus.instr_retired = rstn && (state_q != S_FETCH) && (state_q != S_FAULT) && (state_d == S_FETCH);
        bus.illegal_instr = rstn && illegal_q;
        bus.bus_error     = rstn && bus_error_q;
    end

    // The wait counter only measures one uninterrupted stall, so any state change restarts it.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)
            cnt_d = '0;
        else if (waiting && !bus.mem_ready)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_FETCH;
            cnt_q       <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end
endmodule
